// File: rtl/flatten_buf_25p_pkg.sv
// Shared constants and bank-state encoding for the dense-1 ping-pong feature buffer.
package flatten_buf_25p_pkg;
  localparam int DATA_W    = 16;
  localparam int ROW_LEN   = 25;
  localparam int ROW_NUM   = 16;
  localparam int FRAME_LEN = ROW_LEN * ROW_NUM;  // 400 words per bank
  localparam int IDX_W     = 9;                  // enough for 0..FRAME_LEN
  localparam int ROW_W     = 4;
  localparam int LANE_W    = 5;
  localparam int ADDR_W    = 32;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_e;

  // Negative Q-format words clamp to zero.
  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] w);
    return w[DATA_W-1] ? '0 : w;
  endfunction
endpackage

// File: rtl/flatten_buf_25p_if.sv
// Producer/consumer bus of the flatten buffer: pool-2 write port, dense-1 row read port and status.
interface flatten_buf_25p_if;
  import flatten_buf_25p_pkg::*;

  logic                      wr_en_in;
  logic [ADDR_W-1:0]         wr_addr_in;
  logic [DATA_W-1:0]         wr_data_in;
  logic [ADDR_W-1:0]         rd_addr_in_1P;
  logic [ROW_LEN*DATA_W-1:0] rd_data_out_25P;
  logic                      dense_en_out;
  logic                      work_finished_in;
  logic                      wr_ready_out;
  logic                      overflow_err;
  logic                      addr_err;

  // Environment side: producer + dense-1
  modport master (
    output wr_en_in, wr_addr_in, wr_data_in, rd_addr_in_1P, work_finished_in,
    input  rd_data_out_25P, dense_en_out, wr_ready_out, overflow_err, addr_err
  );

  // Buffer side
  modport slave (
    input  wr_en_in, wr_addr_in, wr_data_in, rd_addr_in_1P, work_finished_in,
    output rd_data_out_25P, dense_en_out, wr_ready_out, overflow_err, addr_err
  );
endinterface

// File: rtl/flatten_buf_25p_idx_to_row_lane.sv
// Linear word index -> (row, lane) split by a compare chain against multiples of ROW_LEN.
module idx_to_row_lane
  import flatten_buf_25p_pkg::*;
(
  input  logic [IDX_W-1:0]  idx_in,
  output logic [ROW_W-1:0]  row_out,
  output logic [LANE_W-1:0] lane_out,
  output logic              oor_out
);
  // Highest multiple of ROW_LEN not above the index wins; no divider needed.
  always_comb begin
    row_out  = '0;
    lane_out = LANE_W'(idx_in);
    oor_out  = (idx_in >= IDX_W'(FRAME_LEN));
    for (int r = 1; r < ROW_NUM; r++) begin
      if (idx_in >= IDX_W'(r * ROW_LEN)) begin
        row_out  = ROW_W'(r);
        lane_out = LANE_W'(idx_in - IDX_W'(r * ROW_LEN));
      end
    end
  end
endmodule

// File: rtl/flatten_buf_25p.sv
// Ping-pong feature buffer between pool-2 and dense-1: word writes in, 25-word rows out.
// Build option: define FLATTEN_RELU_EN to clamp negative words to zero on write.
module flatten_buf_25p
  import flatten_buf_25p_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  flatten_buf_25p_if.slave bus
);
  typedef logic [ROW_LEN-1:0][DATA_W-1:0] row_t;

  row_t              mem_q [2][ROW_NUM];
  bank_state_e       state_q [2], state_d [2];
  logic [IDX_W-1:0]  cnt_q [2], cnt_d [2];
  logic              wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic              dense_en_q, dense_en_d, wr_ready_q, wr_ready_d;
  logic              ovf_q, ovf_d, aerr_q, aerr_d;
  row_t              rd_data_q, rd_data_d;

  logic [ROW_W-1:0]  wr_row;
  logic [LANE_W-1:0] wr_lane;
  logic              idx_oor, addr_bad, bank_open, wr_acc, rel, grant;
  logic [DATA_W-1:0] wr_word;

  idx_to_row_lane u_idx (
    .idx_in   (bus.wr_addr_in[IDX_W-1:0]),
    .row_out  (wr_row),
    .lane_out (wr_lane),
    .oor_out  (idx_oor)
  );

  // Write qualification, release and grant decisions from the registered bank states
  always_comb begin
    addr_bad  = idx_oor || (|bus.wr_addr_in[ADDR_W-1:IDX_W]);
    bank_open = (state_q[wr_sel_q] == BANK_EMPTY) || (state_q[wr_sel_q] == BANK_FILLING);
    wr_acc    = bus.wr_en_in && !addr_bad && bank_open;
    // Only the rd_sel bank can ever be READING, so checking it covers both banks.
    rel       = bus.work_finished_in && (state_q[rd_sel_q] == BANK_READING);
    grant     = (state_q[0] != BANK_READING) && (state_q[1] != BANK_READING) &&
                (state_q[rd_sel_q] == BANK_FULL);
`ifdef FLATTEN_RELU_EN
    wr_word   = relu(bus.wr_data_in);
`else
    wr_word   = bus.wr_data_in;
`endif
  end

  // Bank lifecycle, select pointers, sticky errors and the registered outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    ovf_d    = ovf_q  | (bus.wr_en_in & ~bank_open);
    aerr_d   = aerr_q | (bus.wr_en_in & addr_bad);
    if (wr_acc) begin
      cnt_d[wr_sel_q] = cnt_q[wr_sel_q] + IDX_W'(1);
      if (cnt_q[wr_sel_q] == IDX_W'(FRAME_LEN - 1)) begin
        state_d[wr_sel_q] = BANK_FULL;
        wr_sel_d          = ~wr_sel_q;
      end else begin
        state_d[wr_sel_q] = BANK_FILLING;
      end
    end
    // Release and grant are exclusive: a grant needs no bank READING, so dense_en
    // always drops for at least one cycle between frames.
    if (rel) begin
      state_d[rd_sel_q] = BANK_EMPTY;
      cnt_d[rd_sel_q]   = '0;
      rd_sel_d          = ~rd_sel_q;
    end else if (grant) begin
      state_d[rd_sel_q] = BANK_READING;
    end
    dense_en_d = (state_d[0] == BANK_READING) || (state_d[1] == BANK_READING);
    wr_ready_d = (state_d[wr_sel_d] == BANK_EMPTY) || (state_d[wr_sel_d] == BANK_FILLING);
    // Row data only advances while the reader owns a bank; otherwise it is held.
    rd_data_d = rd_data_q;
    if (dense_en_q) begin
      if (bus.rd_addr_in_1P >= ADDR_W'(ROW_NUM)) rd_data_d = '0;
      else rd_data_d = mem_q[rd_sel_q][bus.rd_addr_in_1P[ROW_W-1:0]];
    end
  end

  // Control/output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= '{default: BANK_EMPTY};
      cnt_q      <= '{default: '0};
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      dense_en_q <= 1'b0;
      wr_ready_q <= 1'b1;
      ovf_q      <= 1'b0;
      aerr_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      dense_en_q <= dense_en_d;
      wr_ready_q <= wr_ready_d;
      ovf_q      <= ovf_d;
      aerr_q     <= aerr_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Bank storage; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_sel_q][wr_row][wr_lane] <= wr_word;
  end

  assign bus.rd_data_out_25P = rd_data_q;
  assign bus.dense_en_out    = dense_en_q;
  assign bus.wr_ready_out    = wr_ready_q;
  assign bus.overflow_err    = ovf_q;
  assign bus.addr_err        = aerr_q;
endmodule

// File: tb/tb_flatten_buf_25p.sv
// Bench for flatten_buf_25p: frame-level reference model, directed scenarios, row table, random traffic.
module tb_flatten_buf_25p;
  import flatten_buf_25p_pkg::*;
  localparam int FW = ROW_LEN * DATA_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flatten_buf_25p_if bif ();
  flatten_buf_25p dut (.clk(clk), .rst_n(rst_n), .bus(bif));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each bank holds a frame; a bank is "done" once 400 words landed
  // and stays done until the reader releases it.
  logic [DATA_W-1:0] m_mem [2][FRAME_LEN];
  int      m_cnt [2];
  bit      m_done [2];
  bit      m_reading;
  int      m_wb, m_rb;
  bit      m_ovf, m_aerr;
  logic [FW-1:0] m_rd;

  typedef struct { int ra; int lane; logic [DATA_W-1:0] exp; } rd_vec_t;
  rd_vec_t tbl [8];

  function automatic logic [DATA_W-1:0] m_store(input logic [DATA_W-1:0] d);
`ifdef FLATTEN_RELU_EN
    return d[DATA_W-1] ? 16'h0000 : d;
`else
    return d;
`endif
  endfunction

  function automatic void m_reset();
    m_cnt = '{0, 0}; m_done = '{0, 0};
    m_reading = 0; m_wb = 0; m_rb = 0;
    m_ovf = 0; m_aerr = 0; m_rd = '0;
  endfunction

  function automatic void m_edge(input bit we, input logic [31:0] a, input logic [15:0] d,
                                 input logic [31:0] ra, input bit wf);
    bit open, rel, grant;
    if (m_reading) begin
      if (ra >= 32'(ROW_NUM)) m_rd = '0;
      else for (int j = 0; j < ROW_LEN; j++)
        m_rd[j*DATA_W +: DATA_W] = m_mem[m_rb][int'(ra) * ROW_LEN + j];
    end
    open  = !m_done[m_wb];
    rel   = wf && m_reading;
    grant = !m_reading && m_done[m_rb];
    if (we && !open) m_ovf = 1;
    if (we && a >= 32'(FRAME_LEN)) m_aerr = 1;
    if (we && open && a < 32'(FRAME_LEN)) begin
      m_mem[m_wb][int'(a)] = m_store(d);
      m_cnt[m_wb]++;
      if (m_cnt[m_wb] == FRAME_LEN) begin
        m_done[m_wb] = 1; m_cnt[m_wb] = 0; m_wb ^= 1;
      end
    end
    if (rel) begin
      m_done[m_rb] = 0; m_reading = 0; m_rb ^= 1;
    end else if (grant) begin
      m_reading = 1;
    end
  endfunction

  function automatic void chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [DATA_W-1:0] lane(input int j);
    return bif.rd_data_out_25P[j*DATA_W +: DATA_W];
  endfunction

  // One clock: drive, advance model at the edge, compare every output 1ns later.
  task automatic step(input bit we, input logic [31:0] a, input logic [15:0] d,
                      input logic [31:0] ra, input bit wf);
    bif.wr_en_in = we; bif.wr_addr_in = a; bif.wr_data_in = d;
    bif.rd_addr_in_1P = ra; bif.work_finished_in = wf;
    @(posedge clk);
    if (!rst_n) m_reset(); else m_edge(we, a, d, ra, wf);
    #1;
    chk("m_dense_en", FW'(bif.dense_en_out), FW'(m_reading));
    chk("m_wr_ready", FW'(bif.wr_ready_out), FW'(!m_done[m_wb]));
    chk("m_overflow", FW'(bif.overflow_err), FW'(m_ovf));
    chk("m_addr_err", FW'(bif.addr_err),     FW'(m_aerr));
    chk("m_rd_data",  bif.rd_data_out_25P,   m_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic fill(input int off, input int n);
    for (int k = 0; k < n; k++) step(1, 32'(k), 16'(k + off), 0, 0);
  endtask

  initial begin
    logic [DATA_W-1:0] exp7;
    tbl[0] = '{3, 0, 16'd75};   tbl[1] = '{3, 24, 16'd99};
    tbl[2] = '{0, 0, 16'd0};    tbl[3] = '{0, 24, 16'd24};
    tbl[4] = '{15, 0, 16'd375}; tbl[5] = '{15, 24, 16'd399};
    tbl[6] = '{9, 13, 16'd238}; tbl[7] = '{16, 5, 16'd0};
`ifdef FLATTEN_RELU_EN
    exp7 = 16'h0000;
`else
    exp7 = 16'h8005;
`endif
    m_reset();
    rst_n = 1'b0;
    idle(2);
    chk("rst_wr_ready", FW'(bif.wr_ready_out), FW'(1));
    chk("rst_dense_en", FW'(bif.dense_en_out), FW'(0));
    rst_n = 1'b1;

    // Bank 0 = index, reader idle: enable 2 cycles after last write
    fill(0, FRAME_LEN);
    chk("lat_edge0", FW'(bif.dense_en_out), FW'(0));
    idle(1);
    chk("lat_edge1", FW'(bif.dense_en_out), FW'(1));
    step(0, 0, 0, 3, 0);
    chk("row3_lane0", FW'(lane(0)), FW'(75));
    chk("row3_lane24", FW'(lane(24)), FW'(99));
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 32'(tbl[i].ra), 0);
      chk($sformatf("tbl%0d", i), FW'(lane(tbl[i].lane)), FW'(tbl[i].exp));
    end

    // Bank 1 = index+1000, no release: both banks full, extra write overflows
    fill(1000, FRAME_LEN);
    chk("both_full_ready", FW'(bif.wr_ready_out), FW'(0));
    step(1, 5, 16'h1234, 0, 0);
    chk("overflow", FW'(bif.overflow_err), FW'(1));
    step(0, 0, 0, 0, 0);
    chk("bank0_kept", FW'(lane(0)), FW'(0));

    // Release with bank 1 waiting: enable low exactly one cycle
    step(0, 0, 0, 0, 1);
    chk("rel_low", FW'(bif.dense_en_out), FW'(0));
    idle(1);
    chk("rel_high", FW'(bif.dense_en_out), FW'(1));
    step(0, 0, 0, 0, 0);
    chk("bank1_row0", FW'(lane(0)), FW'(1000));

    // Out-of-range writes dropped, count untouched
    step(0, 0, 0, 0, 1);
    step(1, 400, 16'h7777, 0, 0);
    step(1, 32'hFFFF, 16'h7777, 0, 0);
    chk("addr_err", FW'(bif.addr_err), FW'(1));
    fill(2000, FRAME_LEN - 1);
    idle(2);
    chk("cnt_399", FW'(bif.dense_en_out), FW'(0));
    step(1, 399, 16'd2399, 0, 0);
    idle(1);
    chk("cnt_400", FW'(bif.dense_en_out), FW'(1));
    step(0, 0, 0, 1, 0);
    chk("row1_lane0", FW'(lane(0)), FW'(2025));
    step(0, 0, 0, 16, 0);
    chk("row16_zero", bif.rd_data_out_25P, '0);

    // Reset mid-frame discards progress
    step(0, 0, 0, 0, 1);
    fill(3000, 200);
    rst_n = 1'b0;
    idle(1);
    chk("mid_rst_dense", FW'(bif.dense_en_out), FW'(0));
    chk("mid_rst_ready", FW'(bif.wr_ready_out), FW'(1));
    chk("mid_rst_ovf", FW'(bif.overflow_err), FW'(0));
    chk("mid_rst_aerr", FW'(bif.addr_err), FW'(0));
    chk("mid_rst_rd", bif.rd_data_out_25P, '0);
    rst_n = 1'b1;
    fill(0, FRAME_LEN - 1);
    idle(2);
    chk("rst_399", FW'(bif.dense_en_out), FW'(0));
    step(1, 399, 16'd399, 0, 0);
    idle(1);
    chk("rst_400", FW'(bif.dense_en_out), FW'(1));

    // Negative word at index 7 of the next frame
    for (int k = 0; k < FRAME_LEN; k++)
      step(1, 32'(k), (k == 7) ? 16'h8005 : 16'(k), 0, 0);
    step(0, 0, 0, 0, 1);
    idle(1);
    step(0, 0, 0, 0, 0);
    chk("relu_lane7", FW'(lane(7)), FW'(exp7));
    chk("relu_lane6", FW'(lane(6)), FW'(6));

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      bit we, wf;
      logic [31:0] a;
      we = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 99) == 0) ? 32'($urandom_range(400, 600)) : 32'($urandom_range(0, 399));
      wf = ($urandom_range(0, 15) == 0);
      step(we, a, 16'($urandom), 32'($urandom_range(0, 17)), wf);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/flatten_buf_25p.md
Name: flatten_buf_25p

Overview:
- Double-buffered (ping-pong) feature buffer directly upstream of the dense-1 layer.
- Accepts the flattened 400-word pool-2 output as single 16-bit writes at linear indices 0..399.
- Serves the dense-1 layer with one 25-word row (400 bits) per read, rows 0..15, and drives that layer's enable.
- While dense-1 consumes one bank, the producer fills the other.

Parameters:
- DATA_W, 16, bits per word
- ROW_LEN, 25, words per row
- ROW_NUM, 16, rows per frame; frame = ROW_LEN*ROW_NUM = 400 words

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- wr_en_in  in  1  producer write strobe
- wr_addr_in  in  32  linear word index 0..399
- wr_data_in  in  16  signed Q-format word
- rd_addr_in_1P  in  32  row index 0..15 from dense-1
- rd_data_out_25P  out  400  row data; lane j at bits [16*j+15:16*j]
- dense_en_out  out  1  enable to dense-1: a full bank is owned by the reader
- work_finished_in  in  1  one-cycle pulse from dense-1: current read bank is released
- wr_ready_out  out  1  a bank is available for writing
- overflow_err  out  1  sticky: write dropped because both banks were full
- addr_err  out  1  sticky: write dropped because wr_addr_in >= 400

Behaviour:
- Reset: all outputs 0, except wr_ready_out = 1. Both banks empty; wr_sel = 0, rd_sel = 0. Bank contents are not cleared. Reset mid-frame discards all progress.
- Per-bank state: EMPTY -> FILLING (first accepted write) -> FULL (400th accepted write) -> READING (granted to reader) -> EMPTY (on work_finished_in).
- Write decode: index k maps to row = k/25, lane = k%25.
  - Accepted when wr_en_in = 1, k < 400, and the write bank is EMPTY or FILLING.
  - A per-bank 9-bit counter increments on each accepted write. Duplicate indices still count; the last data wins.
  - When the counter reaches 400, the bank goes FULL and wr_sel toggles on the next cycle.
- wr_ready_out = 0 when the bank at wr_sel is FULL or READING.
- Dropped writes:
  - Write while wr_ready_out = 0: dropped, overflow_err set.
  - Write with k >= 400: dropped, addr_err set, counter unchanged.
  - Both flags clear only on reset.
- Grant: if no bank is READING and the bank at rd_sel is FULL, it becomes READING. dense_en_out rises the cycle after the bank goes FULL.
- Read: rd_data_out_25P is registered with 1-cycle latency from rd_addr_in_1P, taken from the rd_sel bank.
  - Row >= 16 returns all zeros.
  - Data output is held (not zeroed) when dense_en_out = 0.
- Release: on work_finished_in while READING:
  - bank -> EMPTY, rd_sel toggles, dense_en_out = 0 next cycle.
  - dense_en_out stays low for at least 1 cycle, even if the other bank is already FULL, so dense-1 resets its counters. It re-rises no earlier than 2 cycles after the pulse.
  - work_finished_in while not READING is ignored.
- Simultaneous events:
  - The 400th write and a release in the same cycle both take effect.
  - A write into a bank in the same cycle it is released is dropped (it was not writable in that cycle).
- Latency: last write to dense_en_out = 2 cycles when the reader is idle.

Optional Feature:
- Macro: FLATTEN_RELU_EN.
- Defined: a ReLU is applied on write; words with bit 15 = 1 are stored as 0x0000.
- Undefined: words are stored unmodified.

Decomposition:
- Shared package: DATA_W, ROW_LEN, ROW_NUM, FRAME_LEN = 400, and the bank-state encoding (EMPTY / FILLING / FULL / READING, 2 bits).
- Sub-module idx_to_row_lane: combinational 9-bit index -> 4-bit row + 5-bit lane + 1-bit out_of_range. Implemented as a compare chain against multiples of 25; no divider.

Test Plan:
- Fill bank 0 with data = index (0..399) in order, reader idle -> dense_en_out rises 2 cycles after the last write; reading row 3 returns lane0 = 75 and lane24 = 99 one cycle later.
- Fill both banks (bank 1 data = index + 1000) with no release, then attempt one more write -> wr_ready_out = 0, overflow_err = 1; a later bank-0 row 0 read still returns lane0 = 0.
- Pulse work_finished_in while bank 1 is FULL -> dense_en_out low for exactly 1 cycle, then high; reading row 0 returns lane0 = 1000.
- Write to index 400 and to index 0xFFFF -> both dropped, addr_err = 1, counter unchanged; 400 valid writes are still needed to reach FULL.
- Drive rd_addr_in_1P = 16 -> rd_data_out_25P = 0 after 1 cycle; assert rst_n = 0 after 200 writes -> all outputs at reset values, and 400 fresh writes are needed before dense_en_out rises.
- With FLATTEN_RELU_EN defined, write 0x8005 to index 7 -> row 0 lane 7 reads 0x0000; with it undefined -> reads 0x8005.
